speccy_matrix_to_scancode: RTL
==============================

Name: speccy_matrix_to_scancode

Overview:
- Reverse of the PS/2-to-Spectrum translator. Scans a physical 8x5 Spectrum membrane matrix and debounces every key.
- Each debounced press or release is emitted as a PS/2 set-2 make/break event. The event port matches the translator's input side (scan_received, scan, extended, released) and the keyboard_pressed_status input side.
- Lets a real Spectrum keyboard drive the same keymap path as a PS/2 keyboard.

Parameters:
- SETTLE_CYCLES, 16: clk cycles between driving a row low and sampling the columns.
- DEBOUNCE_SCANS, 4: consecutive full-matrix scans with a changed raw level needed to flip a key's debounced state (range 1..15).
- EVENT_GAP, 32: minimum clk cycles from one scan_received pulse to the next. Must be at least 8, so the translator's 8-cycle lookup finishes.

Ports:
- clk  in  1  system clock (same clock as the PS/2 domain consumer).
- rst  in  1  synchronous, active-high reset.
- row_n  out  8  row select, active low, one-hot-zero; bit r = address line A(8+r).
- col_n  in  5  column sense, active low, asynchronous; double-flop synchronised internally.
- scan_received  out  1  one-cycle strobe; a new event is valid.
- scan  out  8  set-2 scancode; held until the next strobe.
- extended  out  1  E0-prefixed code; held.
- released  out  1  1 = break, 0 = make; held.
- all_released  out  1  1 when no debounced key is down.

Behaviour:
- Reset values: row_n=8'hFF, scan_received=0, scan=8'h00, extended=0, released=0, all_released=1. All debounced states are released, all counters are 0, scan pointer is row 0.
- Reset mid-scan or mid-emit aborts immediately. No release events are generated for keys that were down.
- FSM states:
  - SELECT: drive row_n[r]=0; go to SETTLE.
  - SETTLE: count SETTLE_CYCLES; go to SAMPLE.
  - SAMPLE: latch the synchronised col_n; row_n=8'hFF; go to COMPARE.
  - COMPARE: one column per cycle, c=0..4. If raw level equals the debounced level, clear that key's counter. Otherwise increment it; on reaching DEBOUNCE_SCANS, flip the debounced state, clear the counter, go to EMIT.
  - EMIT: wait until the gap counter is at least EVENT_GAP. Then pulse scan_received for 1 cycle, load scan/extended from the table, set released = new state is up, restart the gap counter, and return to COMPARE at the next column.
  - After c=4, r increments (7 wraps to 0) and the FSM goes to SELECT.
- Scanning stalls during EMIT, so no event is lost. Simultaneous changes are emitted in row-then-column order.
- Gap counter saturates at EVENT_GAP. The first event after reset is not delayed.
- Key index k = 5*r + c. Column bit 0 is the outermost key of the half-row.
- Key map, rows 0..7, col 0..4:
  - row 0: 12,1A,22,21,2A
  - row 1: 1C,1B,23,2B,34
  - row 2: 15,1D,24,2D,2C
  - row 3: 16,1E,26,25,2E
  - row 4: 45,46,3E,3D,36
  - row 5: 4D,44,43,3C,35
  - row 6: 5A,4B,42,3B,33
  - row 7: 29,14(E0),3A,31,32
  - Only Symbol Shift (k=36) is extended; it maps to right Ctrl.
- all_released is updated the cycle after any debounced flip.
- Ghosting and blocking are not handled; raw data is taken as read.

Optional Feature:
- SPECCY_MATRIX_TYPEMATIC_EN defined: adds parameters REPEAT_DELAY (default 500000) and REPEAT_RATE (default 100000).
  - The most recent make event's key becomes the repeat key.
  - After REPEAT_DELAY cycles held, a duplicate make event is emitted, then one every REPEAT_RATE cycles, still subject to EVENT_GAP.
  - Repeat is cancelled by that key's release, by another key's make, or by rst.
- Undefined: no repeat logic, no extra parameters; each press yields exactly one make.

Decomposition:
- Package speccy_kbd_pkg holds:
  - the 40-entry key-to-{extended,scan} constant table;
  - row/column count constants (8, 5);
  - the FSM state encoding.
- One sub-module, speccy_key_debounce: per-key counters plus debounced state array, indexed by k, returning a flip flag. The top keeps the scan FSM and event output.

Test Plan:
- Hold col_n[0]=0 only while row_n[0]=0, for 4 scans with DEBOUNCE_SCANS=4 -> exactly one strobe with scan=12, extended=0, released=0; all_released falls to 0.
- Release that key -> one strobe with scan=12, released=1; all_released returns to 1.
- Press Symbol Shift (row 7, col 1) -> strobe with scan=14, extended=1, released=0.
- Press Q (r2c0) and E (r2c2) in the same scan -> strobes 15 then 24, spaced at least EVENT_GAP=32 cycles apart; scan is held between them.
- Toggle a key's raw level for 3 scans, then back -> no strobe; counter cleared.
- Assert rst for 1 cycle during EMIT with a key held -> outputs at reset values, row_n=8'hFF. The held key produces a fresh make after 4 scans.

Source files
------------

// File: rtl/speccy_kbd_pkg.sv
// Shared constants for the Spectrum membrane scanner: matrix geometry,
// scan FSM encoding and the key-index to PS/2 set-2 code table.
package speccy_kbd_pkg;

  localparam int NUM_ROWS = 8;
  localparam int NUM_COLS = 5;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  typedef enum logic [2:0] {
    ST_SELECT  = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_SAMPLE  = 3'd2,
    ST_COMPARE = 3'd3,
    ST_EMIT    = 3'd4
  } scan_state_t;

  // {extended, scan} per key index k = 5*row + col; only Symbol Shift is E0-prefixed
  localparam logic [8:0] KEY_MAP [NUM_KEYS] = '{
    9'h012, 9'h01A, 9'h022, 9'h021, 9'h02A,
    9'h01C, 9'h01B, 9'h023, 9'h02B, 9'h034,
    9'h015, 9'h01D, 9'h024, 9'h02D, 9'h02C,
    9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E,
    9'h045, 9'h046, 9'h03E, 9'h03D, 9'h036,
    9'h04D, 9'h044, 9'h043, 9'h03C, 9'h035,
    9'h05A, 9'h04B, 9'h042, 9'h03B, 9'h033,
    9'h029, 9'h114, 9'h03A, 9'h031, 9'h032
  };

  function automatic logic [8:0] key_code(input logic [5:0] k);
    key_code = (k < 6'(NUM_KEYS)) ? KEY_MAP[k] : 9'h000;
  endfunction

endpackage

// File: rtl/speccy_key_debounce.sv
// Per-key scan-count debouncer: one saturating change counter and one
// debounced level per key, accessed one key per cycle by index.
module speccy_key_debounce
  import speccy_kbd_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [5:0] k,
  input  logic       raw,
  output logic       flip,
  output logic       any_down
);

  localparam logic [3:0] TC = 4'(DEBOUNCE_SCANS);

  logic [3:0]          cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] deb;

  always_comb flip = en && (raw != deb[k]) && ((cnt[k] + 4'd1) == TC);

  assign any_down = |deb;

  always_ff @(posedge clk) begin
    if (rst) begin
      deb <= '0;
      for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= '0;
    end else if (en) begin
      if (raw == deb[k]) begin
        cnt[k] <= '0;
      end else if (flip) begin
        deb[k] <= raw;
        cnt[k] <= '0;
      end else begin
        cnt[k] <= cnt[k] + 4'd1;
      end
    end
  end

endmodule

// File: rtl/speccy_matrix_to_scancode.sv
// Spectrum 8x5 membrane scanner emitting debounced PS/2 set-2 make/break events.
// Optional auto-repeat of the last made key: define SPECCY_MATRIX_TYPEMATIC_EN.
//
// state      | meaning
// SELECT     | drive current row low (or start a pending repeat event)
// SETTLE     | wait SETTLE_CYCLES for the membrane lines to settle
// SAMPLE     | latch synchronised columns, release the row
// COMPARE    | one column per cycle through the debouncer
// EMIT       | hold until the event gap has elapsed, then strobe the event
module speccy_matrix_to_scancode
  import speccy_kbd_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int EVENT_GAP      = 32
`ifdef SPECCY_MATRIX_TYPEMATIC_EN
  ,
  parameter int REPEAT_DELAY   = 500000,
  parameter int REPEAT_RATE    = 100000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] row_n,
  input  logic [4:0] col_n,
  output logic       scan_received,
  output logic [7:0] scan,
  output logic       extended,
  output logic       released,
  output logic       all_released
);

  localparam int SW    = $clog2(SETTLE_CYCLES + 1);
  localparam int GAP_W = $clog2(EVENT_GAP + 1);

  scan_state_t      state, state_nxt;
  logic [2:0]       row, col;
  logic [SW-1:0]    settle_cnt;
  logic [4:0]       col_sync1, col_sync2, col_lat;
  logic [GAP_W-1:0] gap_cnt;
  logic [5:0]       emit_k, k_cur, rep_key;
  logic             emit_rel, raw_cur, gap_ok, last_col, emit_fire;
  logic             flip, any_down, rep_pending, emit_rpt;

  speccy_key_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .en       (state == ST_COMPARE),
    .k        (k_cur),
    .raw      (raw_cur),
    .flip     (flip),
    .any_down (any_down)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_SELECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_SELECT:  state_nxt = rep_pending ? ST_EMIT : ST_SETTLE;
      ST_SETTLE:  if (settle_cnt == '0) state_nxt = ST_SAMPLE;
      ST_SAMPLE:  state_nxt = ST_COMPARE;
      ST_COMPARE: if (flip) state_nxt = ST_EMIT;
                  else if (last_col) state_nxt = ST_SELECT;
      ST_EMIT:    if (gap_ok) state_nxt = (emit_rpt || last_col) ? ST_SELECT : ST_COMPARE;
      default:    state_nxt = ST_SELECT;
    endcase
  end

  always_comb begin
    k_cur     = ({3'b000, row} * 6'd5) + {3'b000, col};
    raw_cur   = ~col_lat[col];
    last_col  = (col == 3'(NUM_COLS - 1));
    gap_ok    = (gap_cnt >= GAP_W'(EVENT_GAP));
    emit_fire = (state == ST_EMIT) && gap_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row           <= '0;
      col           <= '0;
      row_n         <= 8'hFF;
      settle_cnt    <= '0;
      col_sync1     <= '1;
      col_sync2     <= '1;
      col_lat       <= '1;
      gap_cnt       <= GAP_W'(EVENT_GAP);
      emit_k        <= '0;
      emit_rel      <= 1'b0;
      scan_received <= 1'b0;
      scan          <= 8'h00;
      extended      <= 1'b0;
      released      <= 1'b0;
      all_released  <= 1'b1;
    end else begin
      col_sync1     <= col_n;
      col_sync2     <= col_sync1;
      all_released  <= ~any_down;
      scan_received <= 1'b0;
      if (!gap_ok) gap_cnt <= gap_cnt + GAP_W'(1);
      case (state)
        ST_SELECT: begin
          if (rep_pending) begin
            emit_k   <= rep_key;
            emit_rel <= 1'b0;
          end else begin
            row_n      <= ~(8'd1 << row);
            settle_cnt <= SW'(SETTLE_CYCLES - 1);
          end
        end
        ST_SETTLE: settle_cnt <= settle_cnt - SW'(1);
        ST_SAMPLE: begin
          col_lat <= col_sync2;
          row_n   <= 8'hFF;
        end
        ST_COMPARE: begin
          if (flip) begin
            emit_k   <= k_cur;
            emit_rel <= ~raw_cur;
          end else if (last_col) begin
            col <= '0;
            row <= row + 3'd1;
          end else begin
            col <= col + 3'd1;
          end
        end
        ST_EMIT: begin
          if (gap_ok) begin
            scan_received          <= 1'b1;
            {extended, scan}       <= key_code(emit_k);
            released               <= emit_rel;
            gap_cnt                <= GAP_W'(1);
            // a repeat was injected from SELECT without consuming a column
            if (!emit_rpt) begin
              if (last_col) begin
                col <= '0;
                row <= row + 3'd1;
              end else begin
                col <= col + 3'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SPECCY_MATRIX_TYPEMATIC_EN
  logic        rep_valid, rep_pending_q, emit_rpt_q;
  logic [5:0]  rep_k;
  logic [31:0] rep_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_valid     <= 1'b0;
      rep_pending_q <= 1'b0;
      emit_rpt_q    <= 1'b0;
      rep_k         <= '0;
      rep_cnt       <= '0;
    end else begin
      if (state == ST_SELECT && rep_pending_q) emit_rpt_q <= 1'b1;
      else if (state == ST_COMPARE && flip)    emit_rpt_q <= 1'b0;
      if (emit_fire) begin
        if (emit_rpt_q) begin
          rep_pending_q <= 1'b0;
          rep_cnt       <= 32'(REPEAT_RATE);
        end else if (!emit_rel) begin
          rep_valid     <= 1'b1;
          rep_k         <= emit_k;
          rep_pending_q <= 1'b0;
          rep_cnt       <= 32'(REPEAT_DELAY);
        end else if (emit_k == rep_k) begin
          rep_valid     <= 1'b0;
          rep_pending_q <= 1'b0;
        end
      end else if (rep_valid && !rep_pending_q) begin
        if (rep_cnt == '0) rep_pending_q <= 1'b1;
        else               rep_cnt <= rep_cnt - 32'd1;
      end
    end
  end

  assign rep_pending = rep_pending_q;
  assign emit_rpt    = emit_rpt_q;
  assign rep_key     = rep_k;
`else
  assign rep_pending = 1'b0;
  assign emit_rpt    = 1'b0;
  assign rep_key     = '0;
`endif

endmodule
